// File: rtl/mem_transfer_ctrl.sv
// mem_transfer_ctrl
// Memory-transfer sequencer between core_control, the input port, a
// synchronous-read data memory and the processing register bank.
//   STORE (100): streams mc_data_length words (clamped to the memory depth)
//                from the input handshake into memory, starting at address 0.
//   LOAD  (010): copies the next chunk of up to REG_DEPTH stored words from
//                memory into the register bank; unused slots read as 0.
//   Every operation ends with a one-cycle mc_done pulse. mc_data_done is
//   high once every stored word has been moved into the register bank.
//
// Ports
//   mc_clk, mc_reset      clock, synchronous active-high reset
//   mc_data_contition     command code (100 store, 010 load, 001/000 neutral)
//   mc_data_length        store word count, sampled when STORE is accepted
//   mc_data_in*           input word handshake (ready decoded from state)
//   mc_mem_*              memory address / write enable / write data / read data
//   mc_reg_data           register bank, slot i at [i*DATA_W +: DATA_W]
//   mc_done, mc_data_done operation-complete pulse, all-words-loaded level
//
// Optional build macro MC_CMD_ERR_EN adds a sticky mc_cmd_err output that
// flags illegal codes in IDLE and conflicting commands during an operation.
//
// state  | meaning
// IDLE   | waiting for a new (changed) 100/010 command
// STORE  | accepting input words, one memory write per accepted word
// WLAST  | last store write on the bus, ready already low
// LOAD   | issuing read addresses and capturing returned words
// DONE   | mc_done high for this single cycle

module mem_transfer_ctrl #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 8,
    parameter int REG_DEPTH = 4
) (
    input  logic                        mc_clk,
    input  logic                        mc_reset,
    input  logic [2:0]                  mc_data_contition,
    input  logic [ADDR_W:0]             mc_data_length,
    input  logic [DATA_W-1:0]           mc_data_in,
    input  logic                        mc_data_in_valid,
    output logic                        mc_data_in_ready,
    output logic [ADDR_W-1:0]           mc_mem_addr,
    output logic                        mc_mem_we,
    output logic [DATA_W-1:0]           mc_mem_wdata,
    input  logic [DATA_W-1:0]           mc_mem_rdata,
    output logic [DATA_W*REG_DEPTH-1:0] mc_reg_data,
    output logic                        mc_done,
    output logic                        mc_data_done
`ifdef MC_CMD_ERR_EN
    ,
    output logic                        mc_cmd_err
`endif
);

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_PROC  = 3'b001;
    localparam logic [2:0] CMD_LOAD  = 3'b010;
    localparam logic [2:0] CMD_STORE = 3'b100;

    localparam logic [ADDR_W:0] MEM_DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] REG_DEPTH_W = (ADDR_W+1)'(REG_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_STORE, S_WLAST, S_LOAD, S_DONE} state_t;

    state_t                      state_q;
    logic [2:0]                  last_cmd_q;
    logic [ADDR_W-1:0]           wr_ptr_q;
    logic [ADDR_W-1:0]           rd_ptr_q;
    logic [ADDR_W:0]             len_q;
    logic [ADDR_W:0]             wr_cnt_q;
    logic [ADDR_W:0]             remaining_q;
    logic [ADDR_W:0]             load_n_q;
    logic [ADDR_W:0]             load_cyc_q;
    logic [ADDR_W-1:0]           addr_q;
    logic                        we_q;
    logic [DATA_W-1:0]           wdata_q;
    logic [DATA_W*REG_DEPTH-1:0] reg_q;
    logic                        done_q;
    logic                        data_done_q;

    logic [ADDR_W:0]             store_len_d;
    logic [ADDR_W:0]             load_n_d;
    logic                        cmd_new;

    always_comb begin
        store_len_d = (mc_data_length > MEM_DEPTH) ? MEM_DEPTH : mc_data_length;
        load_n_d    = (remaining_q > REG_DEPTH_W) ? REG_DEPTH_W : remaining_q;
        // a held code must not restart the operation it already triggered
        cmd_new     = ((mc_data_contition == CMD_STORE) || (mc_data_contition == CMD_LOAD))
                      && (mc_data_contition != last_cmd_q);
    end

    assign mc_data_in_ready = (state_q == S_STORE);
    assign mc_mem_addr      = addr_q;
    assign mc_mem_we        = we_q;
    assign mc_mem_wdata     = wdata_q;
    assign mc_reg_data      = reg_q;
    assign mc_done          = done_q;
    assign mc_data_done     = data_done_q;

    always_ff @(posedge mc_clk) begin
        if (mc_reset) begin
            state_q     <= S_IDLE;
            last_cmd_q  <= CMD_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            len_q       <= '0;
            wr_cnt_q    <= '0;
            remaining_q <= '0;
            load_n_q    <= '0;
            load_cyc_q  <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            reg_q       <= '0;
            done_q      <= 1'b0;
            data_done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((mc_data_contition == CMD_IDLE) || (mc_data_contition == CMD_PROC)) begin
                last_cmd_q <= CMD_IDLE;
            end
            case (state_q)
                S_IDLE: begin
                    we_q <= 1'b0;
                    if (cmd_new && (mc_data_contition == CMD_STORE)) begin
                        len_q    <= store_len_d;
                        wr_ptr_q <= '0;
                        wr_cnt_q <= '0;
                        if (store_len_d == '0) begin
                            remaining_q <= '0;
                            rd_ptr_q    <= '0;
                            data_done_q <= 1'b1;
                            done_q      <= 1'b1;
                            last_cmd_q  <= CMD_STORE;
                            state_q     <= S_DONE;
                        end else begin
                            data_done_q <= 1'b0;
                            state_q     <= S_STORE;
                        end
                    end else if (cmd_new) begin
                        if (remaining_q == '0) begin
                            done_q     <= 1'b1;
                            last_cmd_q <= CMD_LOAD;
                            state_q    <= S_DONE;
                        end else begin
                            load_n_q   <= load_n_d;
                            load_cyc_q <= (ADDR_W+1)'(1);
                            addr_q     <= rd_ptr_q;
                            for (int i = 0; i < REG_DEPTH; i++) begin
                                if ((ADDR_W+1)'(i) >= load_n_d) begin
                                    reg_q[i*DATA_W +: DATA_W] <= '0;
                                end
                            end
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_STORE: begin
                    if (mc_data_in_valid) begin
                        we_q     <= 1'b1;
                        addr_q   <= wr_ptr_q;
                        wdata_q  <= mc_data_in;
                        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                        wr_cnt_q <= wr_cnt_q + (ADDR_W+1)'(1);
                        if (wr_cnt_q + (ADDR_W+1)'(1) == len_q) begin
                            state_q <= S_WLAST;
                        end
                    end else begin
                        we_q <= 1'b0;
                    end
                end
                S_WLAST: begin
                    we_q        <= 1'b0;
                    rd_ptr_q    <= '0;
                    remaining_q <= len_q;
                    done_q      <= 1'b1;
                    last_cmd_q  <= CMD_STORE;
                    state_q     <= S_DONE;
                end
                S_LOAD: begin
                    we_q <= 1'b0;
                    // read data lags its address by one cycle, so load cycle t
                    // returns the word addressed in cycle t-1 (slot t-2)
                    for (int i = 0; i < REG_DEPTH; i++) begin
                        if (load_cyc_q == (ADDR_W+1)'(i + 2)) begin
                            reg_q[i*DATA_W +: DATA_W] <= mc_mem_rdata;
                        end
                    end
                    if (load_cyc_q < load_n_q) begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                    load_cyc_q <= load_cyc_q + (ADDR_W+1)'(1);
                    if (load_cyc_q == load_n_q + (ADDR_W+1)'(1)) begin
                        rd_ptr_q    <= rd_ptr_q + load_n_q[ADDR_W-1:0];
                        remaining_q <= remaining_q - load_n_q;
                        data_done_q <= (remaining_q == load_n_q);
                        done_q      <= 1'b1;
                        last_cmd_q  <= CMD_LOAD;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MC_CMD_ERR_EN
    logic cmd_err_q;
    logic cmd_illegal;

    // any code with two or more bits set is not a valid command
    assign cmd_illegal = (mc_data_contition[2] & mc_data_contition[1])
                       | (mc_data_contition[2] & mc_data_contition[0])
                       | (mc_data_contition[1] & mc_data_contition[0]);

    always_ff @(posedge mc_clk) begin
        if (mc_reset) begin
            cmd_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE:          if (cmd_illegal) cmd_err_q <= 1'b1;
                S_STORE, S_WLAST: if (mc_data_contition == CMD_LOAD) cmd_err_q <= 1'b1;
                S_LOAD:          if (mc_data_contition == CMD_STORE) cmd_err_q <= 1'b1;
                default:         cmd_err_q <= cmd_err_q;
            endcase
        end
    end

    assign mc_cmd_err = cmd_err_q;
`endif

endmodule

// File: tb/tb_mem_transfer_ctrl.sv
module tb_mem_transfer_ctrl;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 8;
    localparam int REG_DEPTH = 4;
    localparam int BANK_W    = DATA_W * REG_DEPTH;

    logic                mc_clk;
    logic                mc_reset;
    logic [2:0]          mc_data_contition;
    logic [ADDR_W:0]     mc_data_length;
    logic [DATA_W-1:0]   mc_data_in;
    logic                mc_data_in_valid;
    logic                mc_data_in_ready;
    logic [ADDR_W-1:0]   mc_mem_addr;
    logic                mc_mem_we;
    logic [DATA_W-1:0]   mc_mem_wdata;
    logic [DATA_W-1:0]   mc_mem_rdata;
    logic [BANK_W-1:0]   mc_reg_data;
    logic                mc_done;
    logic                mc_data_done;
`ifdef MC_CMD_ERR_EN
    logic                mc_cmd_err;
`endif

    mem_transfer_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .REG_DEPTH (REG_DEPTH)
    ) dut (
        .mc_clk            (mc_clk),
        .mc_reset          (mc_reset),
        .mc_data_contition (mc_data_contition),
        .mc_data_length    (mc_data_length),
        .mc_data_in        (mc_data_in),
        .mc_data_in_valid  (mc_data_in_valid),
        .mc_data_in_ready  (mc_data_in_ready),
        .mc_mem_addr       (mc_mem_addr),
        .mc_mem_we         (mc_mem_we),
        .mc_mem_wdata      (mc_mem_wdata),
        .mc_mem_rdata      (mc_mem_rdata),
        .mc_reg_data       (mc_reg_data),
        .mc_done           (mc_done),
        .mc_data_done      (mc_data_done)
`ifdef MC_CMD_ERR_EN
        ,
        .mc_cmd_err        (mc_cmd_err)
`endif
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        logic [BANK_W-1:0] bank;
        logic              dd;
        int                cyc;
    } ld_t;

    wr_t               wq[$];
    ld_t               lq[$];
    logic [DATA_W-1:0] mem     [0:63];
    logic [DATA_W-1:0] exp_mem [0:63];

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int wr_count = 0;

    int                m_rem;
    int                m_rd;
    logic              m_dd;
    logic [BANK_W-1:0] m_bank;

    initial mc_clk = 1'b0;
    always #5 mc_clk = ~mc_clk;

    // synchronous-read memory, read-before-write
    always @(posedge mc_clk) begin
        if (mc_mem_we) mem[mc_mem_addr] <= mc_mem_wdata;
        mc_mem_rdata <= mem[mc_mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // write scoreboard: every memory write must match the next expected one
    always @(negedge mc_clk) begin : wr_mon
        wr_t w;
        if (mc_mem_we === 1'b1) begin
            wr_count++;
            if (wq.size() == 0) begin
                chk("wr_unexpected", mc_mem_we, 1'b0);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", mc_mem_addr, w.addr);
                chk("wr_data", mc_mem_wdata, w.data);
            end
        end
    end

    task automatic chk_all_zero();
        chk("z_ready", mc_data_in_ready, 0);
        chk("z_we", mc_mem_we, 0);
        chk("z_addr", mc_mem_addr, 0);
        chk("z_wdata", mc_mem_wdata, 0);
        chk("z_reg", mc_reg_data, 0);
        chk("z_done", mc_done, 0);
        chk("z_data_done", mc_data_done, 0);
`ifdef MC_CMD_ERR_EN
        chk("z_cmd_err", mc_cmd_err, 0);
`endif
    endtask

    task automatic idle_cmd(input logic [2:0] code, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge mc_clk);
            chk("idle_done", mc_done, 0);
            chk("idle_ready", mc_data_in_ready, 0);
            mc_data_contition = code;
        end
    endtask

    task automatic store_op(input int len, input int gap, input logic [7:0] base, input int exp_cyc);
        int   n, nacc, gapcnt, wr0;
        logic pend, seen;
        n = (len > 64) ? 64 : len;
        for (int i = 0; i < n; i++) begin
            wr_t w;
            w.addr = ADDR_W'(i);
            w.data = base + 8'(i);
            wq.push_back(w);
            exp_mem[i] = w.data;
        end
        wr0 = wr_count; nacc = 0; gapcnt = 0; seen = 1'b0;
        @(negedge mc_clk);
        mc_data_contition = 3'b100;
        mc_data_length    = (ADDR_W+1)'(len);
        mc_data_in_valid  = 1'b1;
        mc_data_in        = (n > 0) ? base : 8'hEE;
        pend = mc_data_in_valid && mc_data_in_ready;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(negedge mc_clk);
            if (pend) begin
                nacc++;
                if (nacc == n) chk("st_ready_off", mc_data_in_ready, 0);
                if (gap > 0 && nacc < n) begin
                    mc_data_in_valid = 1'b0;
                    gapcnt = gap;
                end
                mc_data_in = (nacc < n) ? base + 8'(nacc) : 8'hEE;
            end else if (gapcnt > 0) begin
                gapcnt--;
                if (gapcnt == 0) mc_data_in_valid = 1'b1;
            end
            if (mc_done) begin
                chk("st_done_cyc", c, exp_cyc);
                chk("st_data_done", mc_data_done, (n == 0));
                seen = 1'b1;
            end
            pend = mc_data_in_valid && mc_data_in_ready;
        end
        chk("st_seen", seen, 1);
        chk("st_accepts", nacc, n);
        chk("st_writes", wr_count - wr0, n);
        chk("st_wq_empty", wq.size(), 0);
        wq.delete();
        mc_data_in_valid = 1'b0;
        @(negedge mc_clk);
        chk("st_pulse", mc_done, 0);
        m_rem = n; m_rd = 0; m_dd = (n == 0);
    endtask

    task automatic load_op();
        int   n;
        ld_t  e, g;
        logic seen;
        n = (m_rem > REG_DEPTH) ? REG_DEPTH : m_rem;
        e.bank = m_bank;
        if (n > 0) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                e.bank[i*DATA_W +: DATA_W] = (i < n) ? exp_mem[ADDR_W'(m_rd + i)] : '0;
            end
        end
        e.dd  = (n == 0) ? m_dd : (m_rem == n);
        e.cyc = (n == 0) ? 1 : n + 2;
        lq.push_back(e);
        seen = 1'b0;
        @(negedge mc_clk);
        mc_data_contition = 3'b010;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge mc_clk);
            if (mc_done) begin
                g = lq.pop_front();
                chk("ld_done_cyc", c, g.cyc);
                chk("ld_bank", mc_reg_data, g.bank);
                chk("ld_data_done", mc_data_done, g.dd);
                seen = 1'b1;
            end
        end
        chk("ld_seen", seen, 1);
        lq.delete();
        @(negedge mc_clk);
        chk("ld_pulse", mc_done, 0);
        m_bank = e.bank;
        m_rd   = (m_rd + n) % 64;
        m_rem  = m_rem - n;
        m_dd   = e.dd;
    endtask

    task automatic reset_mid_store();
        wr_t w;
        w.addr = 0; w.data = 8'hA0; wq.push_back(w); exp_mem[0] = 8'hA0;
        w.addr = 1; w.data = 8'hA1; wq.push_back(w); exp_mem[1] = 8'hA1;
        @(negedge mc_clk);
        mc_data_contition = 3'b100;
        mc_data_length    = 7'd5;
        mc_data_in_valid  = 1'b1;
        mc_data_in        = 8'hA0;
        @(negedge mc_clk);
        chk("rm_ready", mc_data_in_ready, 1);
        @(negedge mc_clk);
        mc_data_in = 8'hA1;
        @(negedge mc_clk);
        mc_reset   = 1'b1;
        mc_data_in = 8'hA2;
        @(negedge mc_clk);
        mc_reset          = 1'b0;
        mc_data_in_valid  = 1'b0;
        mc_data_contition = 3'b000;
        chk_all_zero();
        chk("rm_wq_empty", wq.size(), 0);
        wq.delete();
        m_rem = 0; m_rd = 0; m_dd = 1'b0; m_bank = '0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = '0;
            exp_mem[i] = '0;
        end
        m_rem = 0; m_rd = 0; m_dd = 1'b0; m_bank = '0;
        mc_reset          = 1'b1;
        mc_data_contition = 3'b000;
        mc_data_length    = '0;
        mc_data_in        = '0;
        mc_data_in_valid  = 1'b0;
        @(negedge mc_clk);
        chk_all_zero();
        mc_reset = 1'b0;

        store_op(6, 0, 8'h11, 8);
        idle_cmd(3'b100, 5);
        load_op();
        idle_cmd(3'b001, 1);
        load_op();
        idle_cmd(3'b000, 1);
        load_op();

        idle_cmd(3'b000, 1);
        store_op(3, 2, 8'h31, 9);
        idle_cmd(3'b111, 3);
`ifdef MC_CMD_ERR_EN
        chk("cmd_err_set", mc_cmd_err, 1);
`endif
        idle_cmd(3'b000, 1);
        load_op();

        idle_cmd(3'b000, 1);
        store_op(0, 0, 8'h00, 1);
        idle_cmd(3'b000, 1);
        load_op();

        idle_cmd(3'b000, 1);
        store_op(64, 0, 8'h40, 66);
        idle_cmd(3'b001, 1);
        load_op();
        idle_cmd(3'b001, 1);
        load_op();

        idle_cmd(3'b000, 1);
        store_op(70, 0, 8'h80, 66);

        idle_cmd(3'b000, 1);
        reset_mid_store();
        store_op(2, 0, 8'hB0, 4);
        idle_cmd(3'b000, 1);
        load_op();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
